// File: rtl/rf_mp.sv
`default_nettype none
// ============================================================================
//  Module   : rf_mp
//  Purpose  : Parametrised multi-port integer register file for the pipelined
//             core. Two combinational read ports, two write ports (port 1,
//             load writeback, wins over port 0, ALU writeback, on a same
//             address collision). Register 0 is hardwired to zero. A
//             sequenced soft-clear engine zeroes registers 1..NREG-1, one per
//             cycle, without using the global reset.
//  Ports    : clk, rst (async, active-high)
//             we0/wa0/wd0  write port 0 (ALU writeback)
//             we1/wa1/wd1  write port 1 (load writeback, higher priority)
//             ra1/rd1, ra2/rd2  combinational read ports
//             clr_req  soft-clear request (sampled in IDLE only)
//             clr_busy high while the soft clear is sweeping the file
//  Options  : `define RF_BYPASS_EN to forward same-cycle write data to the
//             read ports (IDLE only, never for address 0).
//  Revision : 1.0  initial release
// ============================================================================
module rf_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            clr_req,
    output logic            clr_busy
);

    localparam logic [0:0]    c_IDLE      = 1'b0;
    localparam logic [0:0]    c_CLEAR     = 1'b1;
    localparam logic [AW-1:0] c_PTR_FIRST = AW'(1);
    localparam logic [AW-1:0] c_PTR_LAST  = AW'(NREG - 1);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   w_ptr_nxt;
    logic [XLEN-1:0] r_rf [NREG];

    logic            w_idle;
    logic            w_wr0;
    logic            w_wr1;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    // Writes are only honoured in IDLE and never to register 0.
    assign w_idle = (r_state == c_IDLE);
    assign w_wr0  = w_idle && we0 && (wa0 != '0);
    assign w_wr1  = w_idle && we1 && (wa1 != '0);

    // ------------------------------------------------------------------------
    // Soft-clear sequencer
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            c_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = c_CLEAR;
                    w_ptr_nxt   = c_PTR_FIRST;
                end
            end
            c_CLEAR: begin
                // The last register is cleared on the same edge we leave.
                if (r_ptr == c_PTR_LAST) begin
                    w_state_nxt = c_IDLE;
                    w_ptr_nxt   = c_PTR_FIRST;
                end else begin
                    w_ptr_nxt   = r_ptr + AW'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_ptr_nxt   = c_PTR_FIRST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ptr   <= c_PTR_FIRST;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Storage. Entry 0 is reset to zero and never written, so it reads zero.
    // Port 1 is assigned last so it wins an address collision.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (r_state == c_CLEAR) begin
            r_rf[r_ptr] <= '0;
        end else begin
            if (w_wr0) begin
                r_rf[wa0] <= wd0;
            end
            if (w_wr1) begin
                r_rf[wa1] <= wd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd1 = '0;
        if (ra1 != '0) begin
            w_rd1 = r_rf[ra1];
`ifdef RF_BYPASS_EN
            // w_wrN already excludes CLEAR and address 0.
            if (w_wr1 && (wa1 == ra1)) begin
                w_rd1 = wd1;
            end else if (w_wr0 && (wa0 == ra1)) begin
                w_rd1 = wd0;
            end
`endif
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (ra2 != '0) begin
            w_rd2 = r_rf[ra2];
`ifdef RF_BYPASS_EN
            if (w_wr1 && (wa1 == ra2)) begin
                w_rd2 = wd1;
            end else if (w_wr0 && (wa0 == ra2)) begin
                w_rd2 = wd0;
            end
`endif
        end
    end

    assign rd1      = w_rd1;
    assign rd2      = w_rd2;
    assign clr_busy = (r_state == c_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_rf_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_mp
//  Purpose  : Self-checking bench for rf_mp. A behavioural model (an array of
//             register values plus a count of remaining clear cycles) predicts
//             every read and clr_busy. Directed steps are followed by a
//             randomized phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            we0 = 1'b0;
    logic [AW-1:0]   wa0 = '0;
    logic [XLEN-1:0] wd0 = '0;
    logic            we1 = 1'b0;
    logic [AW-1:0]   wa1 = '0;
    logic [XLEN-1:0] wd1 = '0;
    logic [AW-1:0]   ra1 = '0;
    logic [AW-1:0]   ra2 = '0;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            clr_req = 1'b0;
    logic            clr_busy;

    rf_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register values and clear cycles left.
    logic [XLEN-1:0] m_rf [NREG];
    int              m_clr_left = 0;
    int              n_pass     = 0;
    int              n_total    = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] ra);
        if (ra == 0) return '0;
`ifdef RF_BYPASS_EN
        if (m_clr_left == 0) begin
            if (we1 && wa1 == ra) return wd1;
            if (we0 && wa0 == ra) return wd0;
        end
`endif
        return m_rf[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        m_clr_left = 0;
    endtask

    // Apply one rising edge to the model using the currently driven inputs.
    task automatic model_edge();
        if (m_clr_left > 0) begin
            // Registers are cleared in ascending order, 1 first.
            m_rf[NREG - m_clr_left] = '0;
            m_clr_left--;
        end else begin
            if (we0 && wa0 != 0) m_rf[wa0] = wd0;
            if (we1 && wa1 != 0) m_rf[wa1] = wd1;
            if (clr_req) m_clr_left = NREG - 1;
        end
    endtask

    // Inputs are driven at the falling edge; outputs are compared 1 unit later.
    task automatic check_all(input string tag);
        #1;
        check({tag, ".rd1"}, rd1, exp_rd(ra1));
        check({tag, ".rd2"}, rd2, exp_rd(ra2));
        check({tag, ".busy"}, {31'd0, clr_busy}, {31'd0, (m_clr_left != 0)});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    endtask

    // Sweep all addresses on both ports while reset is held (edges are inert).
    task automatic reset_sweep(input string tag);
        for (int i = 0; i < NREG; i++) begin
            ra1 = AW'(i);
            ra2 = AW'(NREG - 1 - i);
            #1;
            check({tag, ".rd1"}, rd1, '0);
            check({tag, ".rd2"}, rd2, '0);
        end
    endtask

    task automatic zero_sweep(input string tag);
        quiet();
        for (int i = 0; i < NREG; i++) begin
            ra1 = AW'(i);
            ra2 = AW'(i);
            #0.1;
            check({tag, ".rd1"}, rd1, '0);
            check({tag, ".rd2"}, rd2, m_rf[i]);
        end
    endtask

    initial begin
        model_reset();

        // ---- Reset pulsed mid-cycle ----
        #12;
        rst = 1'b1;
        #1;
        check("rst.busy", {31'd0, clr_busy}, 32'd0);
        reset_sweep("rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all("post_rst");

        // ---- Basic write / read, write to r0 discarded ----
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra1 = 5'd5; ra2 = 5'd0;
        check_all("wr5.pre");
        tick();
        quiet();
        check_all("wr5.post");
        check("wr5.val", rd1, 32'hDEADBEEF);
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234; ra2 = 5'd0;
        check_all("wr0.pre");
        tick();
        quiet();
        check_all("wr0.post");
        check("wr0.val", rd2, 32'h0);

        // ---- Collision: port 1 wins; distinct addresses both stored ----
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22222222; ra1 = 5'd7;
        check_all("coll.pre");
        tick();
        quiet();
        check_all("coll.post");
        check("coll.val", rd1, 32'h22222222);
        we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22222222;
        tick();
        quiet();
        ra1 = 5'd8; ra2 = 5'd7;
        check_all("split");
        check("split.r8", rd1, 32'h11111111);
        check("split.r7", rd2, 32'h22222222);

        // ---- Same-cycle forwarding (reg 3 still 0) ----
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hCAFEF00D; ra1 = 5'd3; ra2 = 5'd0;
        #1;
`ifdef RF_BYPASS_EN
        check("byp.pre", rd1, 32'hCAFEF00D);
`else
        check("byp.pre", rd1, 32'h0);
`endif
        check("byp.r0", rd2, 32'h0);
        tick();
        quiet();
        check_all("byp.post");
        check("byp.val", rd1, 32'hCAFEF00D);

        // ---- Soft clear sweep ----
        for (int i = 1; i < NREG; i++) begin
            we0 = 1'b1; wa0 = AW'(i); wd0 = XLEN'(i);
            tick();
        end
        quiet();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < NREG - 1; k++) begin
            we0 = 1'b1; wa0 = 5'd9; wd0 = $urandom;
            clr_req = k[0];
            ra1 = AW'(k + 1);
            ra2 = AW'(k);
            check_all("clr.step");
            check("clr.next", rd1, XLEN'(k + 1));
            check("clr.done", rd2, 32'h0);
            tick();
        end
        quiet();
        check_all("clr.end");
        zero_sweep("clr.zero");

        // ---- Reset in the middle of a clear ----
        for (int i = 1; i < NREG; i++) begin
            we1 = 1'b1; wa1 = AW'(i); wd1 = $urandom;
            tick();
        end
        quiet();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check_all("mid.busy");
        #2;
        rst = 1'b1;
        #1;
        check("mid.rst.busy", {31'd0, clr_busy}, 32'd0);
        reset_sweep("mid.rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all("mid.release");
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < NREG - 1; k++) begin
            check("reclr.busy", {31'd0, clr_busy}, 32'd1);
            tick();
        end
        check("reclr.idle", {31'd0, clr_busy}, 32'd0);

        // ---- Randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            we0     = 1'($urandom);
            wa0     = AW'($urandom);
            wd0     = $urandom;
            we1     = 1'($urandom);
            wa1     = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom);
            wd1     = $urandom;
            ra1     = ($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom);
            ra2     = ($urandom_range(0, 2) == 0) ? wa0 : AW'($urandom);
            clr_req = ($urandom_range(0, 59) == 0);
            check_all("rand");
            tick();
        end
        quiet();
        check_all("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
